// File: rtl/riscv_pkg.sv
// Types and funct3 encodings shared by the MEM-stage load/store unit.
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

endpackage

// File: rtl/mem_lsu_align.sv
// Byte-lane steering for the LSU: store enables/replication, load extract/extend,
// and the legality check for the size/offset/funct3 combination.
module mem_lsu_align
    import riscv_pkg::*;
(
    input  logic        st,
    input  logic [2:0]  func,
    input  logic [1:0]  offs,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic        legal,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_fmt
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (offs)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = offs[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        legal      = 1'b1;
        be         = 4'b1111;
        wdata_lane = wdata;
        rdata_fmt  = rdata;
        case (func)
            F3_B, F3_BU: begin
                // unsigned forms only exist for loads
                legal      = (func == F3_B) || !st;
                be         = 4'b0001 << offs;
                wdata_lane = {4{wdata[7:0]}};
                rdata_fmt  = (func == F3_B) ? {{24{byte_sel[7]}}, byte_sel} : {24'b0, byte_sel};
            end
            F3_H, F3_HU: begin
                legal      = !offs[0] && ((func == F3_H) || !st);
                be         = offs[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata[15:0]}};
                rdata_fmt  = (func == F3_H) ? {{16{half_sel[15]}}, half_sel} : {16'b0, half_sel};
            end
            F3_W: begin
                legal = (offs == 2'b00);
            end
            default: begin
                legal      = 1'b0;
                be         = 4'b0000;
                wdata_lane = '0;
                rdata_fmt  = '0;
            end
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: one req/gnt (+rvalid for loads) bus transaction per
// EX/MEM memory op, with stall to the hazard unit and a bus timeout.
//
//  state | meaning
//  IDLE  | waiting for a load/store in EX/MEM; illegal ops pulse o_misalign here
//  REQ   | request on the bus, attributes held until gnt
//  RSP   | load granted, waiting for rvalid
//  DONE  | result presented on o_rdata/o_done; parked while i_hold
module mem_lsu
    import riscv_pkg::*;
#(
    parameter int MAX_WAIT = 255
)
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_ld,
    input  logic        i_st,
    input  logic [2:0]  i_func,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic        i_hold,
    output logic        o_stall,
    output logic [31:0] o_rdata,
    output logic        o_done,
    output logic        o_misalign,
    output logic        o_err,
    output logic        o_dmem_req,
    input  logic        i_dmem_gnt,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [3:0]  o_dmem_be,
    output logic [31:0] o_dmem_wdata,
    input  logic        i_dmem_rvalid,
    input  logic [31:0] i_dmem_rdata
);

    localparam int            CW      = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_WAIT);

    lsu_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic [31:0]   rdata_q;
    logic          run_q;
    logic          req, cnt_inc, cap_rdata, clr_rdata, timeout;
    logic          legal;
    logic [3:0]    be;
    logic [31:0]   wdata_lane, rdata_fmt;

    mem_lsu_align u_align (
        .st         (i_st),
        .func       (i_func),
        .offs       (i_addr[1:0]),
        .wdata      (i_wdata),
        .rdata      (i_dmem_rdata),
        .legal      (legal),
        .be         (be),
        .wdata_lane (wdata_lane),
        .rdata_fmt  (rdata_fmt)
    );

    assign timeout = (cnt_q == CNT_MAX);

    always_comb begin
        state_d    = state_q;
        o_stall    = 1'b0;
        o_done     = 1'b0;
        o_misalign = 1'b0;
        o_err      = 1'b0;
        req        = 1'b0;
        cnt_inc    = 1'b0;
        cap_rdata  = 1'b0;
        clr_rdata  = 1'b0;
        case (state_q)
            IDLE: begin
                // run_q keeps IDLE outputs quiet while reset is asserted
                if (run_q && (i_ld || i_st)) begin
                    if (legal) begin
                        o_stall = 1'b1;
                        state_d = REQ;
                    end else begin
                        o_misalign = 1'b1;
                    end
                end
            end
            REQ: begin
                o_stall = 1'b1;
                if (timeout) begin
                    o_err     = 1'b1;
                    clr_rdata = 1'b1;
                    state_d   = DONE;
                end else begin
                    req     = 1'b1;
                    cnt_inc = 1'b1;
                    if (i_dmem_gnt) begin
                        if (i_st) begin
                            clr_rdata = 1'b1;
                            state_d   = DONE;
                        end else begin
                            state_d = RSP;
                        end
                    end
                end
            end
            RSP: begin
                o_stall = 1'b1;
                if (timeout) begin
                    o_err     = 1'b1;
                    clr_rdata = 1'b1;
                    state_d   = DONE;
                end else begin
                    cnt_inc = 1'b1;
                    if (i_dmem_rvalid) begin
                        cap_rdata = 1'b1;
                        state_d   = DONE;
                    end
                end
            end
            DONE: begin
                o_done = 1'b1;
                if (!i_hold) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
            if (state_q == IDLE && state_d == REQ) cnt_q <= '0;
            else if (cnt_inc)                      cnt_q <= cnt_q + 1'b1;
            if (clr_rdata)      rdata_q <= '0;
            else if (cap_rdata) rdata_q <= rdata_fmt;
        end
    end

    assign o_rdata      = (state_q == DONE) ? rdata_q : '0;
    assign o_dmem_req   = req;
    assign o_dmem_we    = req & i_st;
    assign o_dmem_addr  = req ? {i_addr[31:2], 2'b00} : '0;
    assign o_dmem_be    = req ? be : '0;
    assign o_dmem_wdata = (req && i_st) ? wdata_lane : '0;

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu: byte-addressed memory model, randomized bus
// responder, and an event monitor comparing done/misalign/err against a queue.
module tb_mem_lsu;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_ld = 1'b0, i_st = 1'b0, i_hold = 1'b0;
    logic [2:0]  i_func = 3'b0;
    logic [31:0] i_addr = '0, i_wdata = '0;
    logic        i_dmem_gnt = 1'b0, i_dmem_rvalid = 1'b0;
    logic [31:0] i_dmem_rdata = '0;
    logic        o_stall, o_done, o_misalign, o_err, o_dmem_req, o_dmem_we;
    logic [31:0] o_rdata, o_dmem_addr, o_dmem_wdata;
    logic [3:0]  o_dmem_be;

    always #5 i_clk = ~i_clk;

    mem_lsu #(.MAX_WAIT(8)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_ld(i_ld), .i_st(i_st), .i_func(i_func),
        .i_addr(i_addr), .i_wdata(i_wdata), .i_hold(i_hold), .o_stall(o_stall),
        .o_rdata(o_rdata), .o_done(o_done), .o_misalign(o_misalign), .o_err(o_err),
        .o_dmem_req(o_dmem_req), .i_dmem_gnt(i_dmem_gnt), .o_dmem_we(o_dmem_we),
        .o_dmem_addr(o_dmem_addr), .o_dmem_be(o_dmem_be), .o_dmem_wdata(o_dmem_wdata),
        .i_dmem_rvalid(i_dmem_rvalid), .i_dmem_rdata(i_dmem_rdata)
    );

    typedef struct { int kind; logic [31:0] rdata; int stall; } ev_t;   // kind: 0 done, 1 misalign, 2 err
    typedef struct { logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata; } bus_t;

    ev_t         ev_q[$];
    bus_t        bus_q[$];
    int          vectors = 0, miscompares = 0;
    logic [7:0]  mem [0:2047];
    int          gnt_left = 0, rsp_delay = 1, rsp_pending = 0, stall_run = 0;
    bit          no_gnt = 1'b0;
    logic [31:0] rd_addr = '0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endfunction

    function automatic int size_of(logic [2:0] f);
        case (f)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic bit is_legal(bit st, logic [2:0] f, logic [31:0] a);
        int sz = size_of(f);
        if (sz == 0) return 1'b0;
        if (st && f[2]) return 1'b0;
        return (a % sz) == 0;
    endfunction

    function automatic logic [31:0] word_at(logic [31:0] a);
        logic [10:0] w = {a[10:2], 2'b00};
        return {mem[w + 11'd3], mem[w + 11'd2], mem[w + 11'd1], mem[w]};
    endfunction

    function automatic logic [31:0] load_val(logic [2:0] f, logic [31:0] a);
        int sz = size_of(f);
        logic [31:0] v = '0;
        for (int i = 0; i < sz; i++) v[8*i +: 8] = mem[a[10:0] + 11'(i)];
        if (!f[2] && sz < 4 && v[8*sz-1])
            for (int i = 8*sz; i < 32; i++) v[i] = 1'b1;
        return v;
    endfunction

    // bus responder: grants after gnt_left cycles, returns load data rsp_delay cycles later
    always @(negedge i_clk) begin : responder
        bus_t b;
        i_dmem_gnt    = 1'b0;
        i_dmem_rvalid = 1'b0;
        if (!i_rst_n) begin
            rsp_pending = 0;
        end else if (o_dmem_req && !no_gnt && gnt_left == 0) begin
            i_dmem_gnt = 1'b1;
            if (bus_q.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL bus_unexpected: request at 0x%08h, expected none", o_dmem_addr);
            end else begin
                b = bus_q.pop_front();
                check("bus_addr", o_dmem_addr, b.addr);
                check("bus_we", 32'(o_dmem_we), 32'(b.we));
                if (b.we) begin
                    check("bus_be", 32'(o_dmem_be), 32'(b.be));
                    check("bus_wdata", o_dmem_wdata, b.wdata);
                end
            end
            if (!o_dmem_we) begin
                rsp_pending = rsp_delay;
                rd_addr     = o_dmem_addr;
            end
        end else if (o_dmem_req && !no_gnt) begin
            gnt_left--;
        end else if (rsp_pending > 0) begin
            rsp_pending--;
            if (rsp_pending == 0) begin
                i_dmem_rvalid = 1'b1;
                i_dmem_rdata  = word_at(rd_addr);
            end
        end
        if (i_rst_n && !i_dmem_rvalid && rsp_pending == 0 && $urandom_range(7) == 0) begin
            i_dmem_rvalid = 1'b1;
            i_dmem_rdata  = $urandom;
        end
    end

    always @(negedge i_clk) begin : monitor
        ev_t e;
        int  kind;
        if (!i_rst_n) begin
            stall_run = 0;
        end else begin
            check("exclusive_pulses", 32'($countones({o_done, o_misalign, o_err}) > 1), 32'd0);
            if (!o_dmem_req)
                check("bus_idle_zero", 32'(|{o_dmem_we, o_dmem_be, o_dmem_addr, o_dmem_wdata}), 32'd0);
            kind = o_misalign ? 1 : o_err ? 2 : (o_done && !i_hold) ? 0 : -1;
            if (kind >= 0) begin
                if (ev_q.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL unexpected_event: kind %0d, expected none", kind);
                end else begin
                    e = ev_q.pop_front();
                    check("event_kind", 32'(kind), 32'(e.kind));
                    if (kind != 2) check("rdata", o_rdata, e.rdata);
                    if (kind == 1) check("misalign_stall", 32'(o_stall), 32'd0);
                    if (e.stall >= 0) check("stall_cycles", 32'(stall_run), 32'(e.stall));
                end
                stall_run = 0;
            end else if (o_stall) begin
                stall_run++;
            end
        end
    end

    task automatic clear_op();
        i_ld = 1'b0; i_st = 1'b0; i_func = 3'b0; i_addr = '0; i_wdata = '0; i_hold = 1'b0;
    endtask

    task automatic issue(bit ld, bit st, logic [2:0] f, logic [31:0] a, logic [31:0] w,
                         int gw, int rd, int hold_n);
        bit   ok = 1'b0;
        int   sz = size_of(f);
        int   hl = hold_n;
        ev_t  e;
        bus_t b;
        if (!is_legal(st, f, a)) begin
            e = '{kind: 1, rdata: 32'd0, stall: 0};
            ev_q.push_back(e);
            i_ld = ld; i_st = st; i_func = f; i_addr = a; i_wdata = w;
            @(posedge i_clk); #1;
            clear_op();
            return;
        end
        b.addr = {a[31:2], 2'b00}; b.we = st; b.be = '0; b.wdata = '0;
        for (int i = 0; i < sz; i++) b.be[a[1:0] + 2'(i)] = 1'b1;
        for (int j = 0; j < 4; j++) b.wdata[8*j +: 8] = w[8*(j % sz) +: 8];
        bus_q.push_back(b);
        e = '{kind: 0, rdata: st ? 32'd0 : load_val(f, a), stall: 2 + gw + (st ? 0 : rd)};
        ev_q.push_back(e);
        gnt_left = gw; rsp_delay = rd;
        i_ld = ld; i_st = st; i_func = f; i_addr = a; i_wdata = w; i_hold = 1'b0;
        for (int c = 0; c < 60 && !ok; c++) begin
            @(posedge i_clk); #1;
            if (o_done) begin
                if (hl > 0) begin i_hold = 1'b1; hl--; end
                else begin i_hold = 1'b0; ok = 1'b1; end
            end
        end
        if (!ok) begin
            vectors++; miscompares++;
            $display("FAIL op_timeout: no o_done for addr 0x%08h within 60 cycles, expected completion", a);
        end
        @(posedge i_clk); #1;
        clear_op();
        if (st) for (int i = 0; i < sz; i++) mem[a[10:0] + 11'(i)] = w[8*i +: 8];
    endtask

    task automatic timeout_op(logic [31:0] a);
        bit  seen = 1'b0;
        int  n = 0;
        ev_t e;
        no_gnt = 1'b1;
        e = '{kind: 2, rdata: 32'd0, stall: -1}; ev_q.push_back(e);
        e = '{kind: 0, rdata: 32'd0, stall: -1}; ev_q.push_back(e);
        i_ld = 1'b1; i_func = 3'b010; i_addr = a;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge i_clk);
            if (o_err) seen = 1'b1;
            else if (o_dmem_req) n++;
        end
        check("timeout_seen", 32'(seen), 32'd1);
        check("timeout_req_cycles", 32'(n), 32'd8);
        @(posedge i_clk); #1;
        check("timeout_done", 32'(o_done), 32'd1);
        @(posedge i_clk); #1;
        clear_op();
        no_gnt = 1'b0;
        repeat (6) @(posedge i_clk);
        #1;
    endtask

    task automatic reset_mid_rsp();
        bus_t b = '{addr: 32'h40, we: 1'b0, be: 4'hF, wdata: 32'd0};
        bus_q.push_back(b);
        gnt_left = 0; rsp_delay = 4;
        i_ld = 1'b1; i_func = 3'b010; i_addr = 32'h40;
        @(posedge i_clk); #1;
        @(posedge i_clk); #1;
        check("rsp_stall", 32'(o_stall), 32'd1);
        i_rst_n = 1'b0;
        #1;
        check("reset_async_outputs", 32'(|{o_stall, o_done, o_misalign, o_err, o_dmem_req,
              o_dmem_we, o_dmem_be, o_dmem_addr, o_dmem_wdata}), 32'd0);
        check("reset_async_rdata", o_rdata, 32'd0);
        @(posedge i_clk); #1;
        check("reset_held_outputs", 32'(|{o_stall, o_misalign, o_dmem_req}), 32'd0);
        clear_op();
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        issue(1'b0, 1'b1, 3'b000, 32'h3, 32'h0000_00A5, 0, 1, 0);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [2:0] funcs [8] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
        for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);
        repeat (3) @(posedge i_clk);
        #1;
        i_ld = 1'b1;
        #1;
        check("reset_state_outputs", 32'(|{o_stall, o_done, o_misalign, o_err, o_dmem_req, o_rdata}), 32'd0);
        i_ld = 1'b0;
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        issue(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 1, 0);
        {mem[11'h203], mem[11'h202], mem[11'h201], mem[11'h200]} = 32'h80FF_FFFF;
        issue(1'b1, 1'b0, 3'b000, 32'h203, 32'h0, 0, 1, 0);
        issue(1'b1, 1'b0, 3'b100, 32'h203, 32'h0, 0, 1, 1);
        {mem[11'h203], mem[11'h202], mem[11'h201], mem[11'h200]} = 32'h8001_0000;
        issue(1'b1, 1'b0, 3'b101, 32'h202, 32'h0, 0, 1, 0);
        issue(1'b0, 1'b1, 3'b001, 32'h101, 32'h1234, 0, 1, 0);
        issue(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 0, 1, 0);
        issue(1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 0, 1, 0);
        issue(1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 5, 2, 0);
        timeout_op(32'h108);
        reset_mid_rsp();

        for (int n = 0; n < 200; n++) begin
            bit st = 1'($urandom);
            issue(!st, st, funcs[$urandom_range(7)], 32'($urandom_range(2047)), $urandom,
                  $urandom_range(3), $urandom_range(1, 3), $urandom_range(2));
        end

        repeat (4) @(posedge i_clk);
        #1;
        check("ev_queue_drained", 32'(ev_q.size()), 32'd0);
        check("bus_queue_drained", 32'(bus_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
